sort_sequencer: RTL and testbench

Multi-cycle execution unit for the SORT instruction. It captures N operand words, sorts them ascending with odd-even transposition (one pass per cycle), then writes them back one per cycle through the single register-file write port to Rd_base..Rd_base+N-1.
Its sort_cycle_count output is the producer end of the hazard unit's sort_cycle_count input. While it is high, the front end is held stalled.

---
 rtl/sort_sequencer.sv | 129 ++++++++++++
 tb/tb_sort_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_sequencer.sv
// SORT instruction execution unit: captures N words, sorts them ascending with
// odd-even transposition (one pass per cycle), then writes them back one per cycle.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SORT  | one odd-even transposition pass per cycle, p = pass index
// WRITE | word[i] written to (base+i) mod 16, done on the last word
module sort_sequencer #(
   parameter int N      = 4,
   parameter int WIDTH  = 32,
   parameter int SIGNED = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           dest_base,
   input  logic [N*WIDTH-1:0]   data_in,
   output logic                 sort_cycle_count,
   output logic                 wb_en,
   output logic [3:0]           wb_dest,
   output logic [WIDTH-1:0]     wb_value,
   output logic                 done
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, SORT, WRITE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    p, p_nxt;
   logic [CW-1:0]    i, i_nxt;
   logic [3:0]       base;
   logic [WIDTH-1:0] words      [N];
   logic [WIDTH-1:0] pass_words [N];
   logic             load;
   logic             pass_en;

   function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) > $signed(b);
      else             return a > b;
   endfunction

   // Pairs within one pass are disjoint, so every compare reads the registered array.
   always_comb begin
      pass_words = words;
      for (int j = 0; j < N - 1; j++) begin
         if ((j % 2) == int'(p[0]) && gt(words[j], words[j+1])) begin
            pass_words[j]   = words[j+1];
            pass_words[j+1] = words[j];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      p_nxt     = p;
      i_nxt     = i;
      load      = 1'b0;
      pass_en   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               p_nxt     = '0;
               state_nxt = SORT;
            end
         end
         SORT: begin
            pass_en = 1'b1;
            if (p == LAST) begin
               p_nxt     = '0;
               i_nxt     = '0;
               state_nxt = WRITE;
            end else begin
               p_nxt = p + 1'b1;
            end
         end
         WRITE: begin
            if (i == LAST) begin
               i_nxt     = '0;
               state_nxt = IDLE;
            end else begin
               i_nxt = i + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         p     <= '0;
         i     <= '0;
         base  <= '0;
      end else begin
         state <= state_nxt;
         p     <= p_nxt;
         i     <= i_nxt;
         if (load) base <= dest_base;
      end
   end

   // Data array needs no reset: it is only observable in WRITE, which always follows a load.
   always_ff @(posedge clk) begin
      if (rst && load) begin
         for (int k = 0; k < N; k++) words[k] <= data_in[k*WIDTH +: WIDTH];
      end else if (rst && pass_en) begin
         words <= pass_words;
      end
   end

   assign sort_cycle_count = start | (state != IDLE);

   always_comb begin
      wb_en    = 1'b0;
      done     = 1'b0;
      wb_dest  = '0;
      wb_value = '0;
      if (state == WRITE) begin
         wb_en    = 1'b1;
         wb_dest  = base + 4'(i);
         wb_value = words[i];
         done     = (i == LAST);
      end
   end

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: a signed and an unsigned instance share stimulus and
// are checked each cycle against a timeline model of the SORT operation.
module tb_sort_sequencer;
   localparam int N = 4;
   localparam int W = 32;
   localparam int VW = 2 * (W + 7);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [3:0]     dest_base = '0;
   logic [N*W-1:0] data_in = '0;

   logic           scc_s, en_s, done_s, scc_u, en_u, done_u;
   logic [3:0]     dest_s, dest_u;
   logic [W-1:0]   val_s, val_u;

   sort_sequencer #(.N(N), .WIDTH(W), .SIGNED(1)) dut (
      .clk(clk), .rst(rst), .start(start), .dest_base(dest_base), .data_in(data_in),
      .sort_cycle_count(scc_s), .wb_en(en_s), .wb_dest(dest_s), .wb_value(val_s), .done(done_s));

   sort_sequencer #(.N(N), .WIDTH(W), .SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .start(start), .dest_base(dest_base), .data_in(data_in),
      .sort_cycle_count(scc_u), .wb_en(en_u), .wb_dest(dest_u), .wb_value(val_u), .done(done_u));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: t = cycles since the accepting cycle (0 = idle), plus the sorted result.
   int           t = 0;
   logic [W-1:0] srt_s [N];
   logic [W-1:0] srt_u [N];
   logic [3:0]   m_base = '0;
   logic         e_scc, e_en, e_done;
   logic [3:0]   e_dest;
   logic [W-1:0] e_val_s, e_val_u;

   function automatic logic [N*W-1:0] pack(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                           input logic [W-1:0] w2, input logic [W-1:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   function automatic bit less(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
      return sgn ? ($signed(a) < $signed(b)) : (a < b);
   endfunction

   task automatic model_capture(input logic [N*W-1:0] d, input logic [3:0] b);
      logic [W-1:0] tmp;
      for (int k = 0; k < N; k++) begin
         srt_s[k] = d[k*W +: W];
         srt_u[k] = d[k*W +: W];
      end
      for (int a = 0; a < N; a++)
         for (int c = a + 1; c < N; c++) begin
            if (less(srt_s[c], srt_s[a], 1'b1)) begin tmp = srt_s[a]; srt_s[a] = srt_s[c]; srt_s[c] = tmp; end
            if (less(srt_u[c], srt_u[a], 1'b0)) begin tmp = srt_u[a]; srt_u[a] = srt_u[c]; srt_u[c] = tmp; end
         end
      m_base = b;
   endtask

   // Drive one cycle's inputs and form the expected outputs; leaves time mid-cycle.
   task automatic tick(input bit r, input bit s, input logic [N*W-1:0] d, input logic [3:0] b);
      rst = r; start = s; data_in = d; dest_base = b;
      e_scc  = s || (t != 0);
      e_en   = (t > N);
      e_done = (t == 2 * N);
      e_dest = '0; e_val_s = '0; e_val_u = '0;
      if (e_en) begin
         e_dest  = m_base + 4'(t - N - 1);
         e_val_s = srt_s[t - N - 1];
         e_val_u = srt_u[t - N - 1];
      end
      #3;
   endtask

   task automatic adv();
      bit r_now, s_now;
      r_now = rst; s_now = start;
      if (!r_now) t = 0;
      else if (t == 0 && s_now) begin model_capture(data_in, dest_base); t = 1; end
      else if (t != 0) t = (t == 2 * N) ? 0 : t + 1;
      @(posedge clk); #1;
   endtask

   function automatic logic [VW-1:0] got_v();
      return {scc_s, en_s, done_s, dest_s, val_s, scc_u, en_u, done_u, dest_u, val_u};
   endfunction

   function automatic logic [VW-1:0] exp_v();
      return {e_scc, e_en, e_done, e_dest, e_val_s, e_scc, e_en, e_done, e_dest, e_val_u};
   endfunction

   task automatic test_reset();
      tick(1'b0, 1'b0, '0, 4'd0);
      total++;
      if ({scc_s, en_s, done_s, dest_s, val_s} !== '0) begin
         bad++; $display("FAIL reset_idle got=%h req=0", {scc_s, en_s, done_s, dest_s, val_s});
      end
      adv();
      // start during reset: stall asserts combinationally, but nothing is captured
      tick(1'b0, 1'b1, pack(1, 2, 3, 4), 4'd3);
      total++;
      if (got_v() !== exp_v()) begin bad++; $display("FAIL reset_start got=%h req=%h", got_v(), exp_v()); end
      adv();
      for (int c = 0; c < 10; c++) begin
         tick(1'b1, 1'b0, '0, 4'd0);
         total++;
         if (got_v() !== exp_v() || scc_s !== 1'b0) begin
            bad++; $display("FAIL reset_no_capture c=%0d got=%h req=%h", c, got_v(), exp_v());
         end
         adv();
      end
   endtask

   task automatic test_basic();
      logic [3:0] wd[$];
      logic [W-1:0] wv[$];
      logic [3:0] xd [N];
      logic [W-1:0] xv [N];
      int dcyc = -1;
      xd = '{4'd2, 4'd3, 4'd4, 4'd5};
      xv = '{32'd1, 32'd3, 32'd5, 32'd9};
      for (int c = 0; c < 10; c++) begin
         tick(1'b1, c == 0, pack(5, 3, 9, 1), 4'd2);
         total++;
         if (got_v() !== exp_v()) begin bad++; $display("FAIL basic c=%0d got=%h req=%h", c, got_v(), exp_v()); end
         if (en_s === 1'b1) begin wd.push_back(dest_s); wv.push_back(val_s); end
         if (done_s === 1'b1) dcyc = c;
         adv();
      end
      total++;
      if (wd.size() != N || dcyc != 8) begin
         bad++; $display("FAIL basic_count writes=%0d done_cycle=%0d req 4 and 8", wd.size(), dcyc);
      end else begin
         for (int k = 0; k < N; k++) begin
            total++;
            if (wd[k] !== xd[k] || wv[k] !== xv[k]) begin
               bad++; $display("FAIL basic_write%0d got R%0d=%0d req R%0d=%0d", k, wd[k], wv[k], xd[k], xv[k]);
            end
         end
      end
   endtask

   task automatic test_signedness();
      logic [W-1:0] vs[$];
      logic [W-1:0] vu[$];
      logic [W-1:0] xs [N];
      logic [W-1:0] xu [N];
      xs = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd7};
      xu = '{32'd2, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
      for (int c = 0; c < 10; c++) begin
         tick(1'b1, c == 0, pack(32'hFFFF_FFFF, 2, 32'h8000_0000, 7), 4'd0);
         total++;
         if (got_v() !== exp_v()) begin bad++; $display("FAIL signedness c=%0d got=%h req=%h", c, got_v(), exp_v()); end
         if (en_s === 1'b1) vs.push_back(val_s);
         if (en_u === 1'b1) vu.push_back(val_u);
         adv();
      end
      for (int k = 0; k < N; k++) begin
         total++;
         if (k >= vs.size() || k >= vu.size() || vs[k] !== xs[k] || vu[k] !== xu[k]) begin
            bad++; $display("FAIL signed_order%0d got s=%h u=%h req s=%h u=%h", k, vs[k], vu[k], xs[k], xu[k]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] wd[$];
      logic [3:0] xd [N];
      xd = '{4'd14, 4'd15, 4'd0, 4'd1};
      for (int c = 0; c < 10; c++) begin
         tick(1'b1, c == 0, pack(4, 3, 2, 1), 4'd14);
         total++;
         if (got_v() !== exp_v()) begin bad++; $display("FAIL wrap c=%0d got=%h req=%h", c, got_v(), exp_v()); end
         if (en_s === 1'b1) begin
            wd.push_back(dest_s);
            total++;
            if (val_s !== 32'(wd.size())) begin bad++; $display("FAIL wrap_val got=%0d req=%0d", val_s, wd.size()); end
         end
         adv();
      end
      for (int k = 0; k < N; k++) begin
         total++;
         if (k >= wd.size() || wd[k] !== xd[k]) begin bad++; $display("FAIL wrap_dest%0d got=%0d req=%0d", k, wd[k], xd[k]); end
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      logic [N*W-1:0] d;
      for (int c = 0; c < 20; c++) begin
         d = (c == 0) ? pack(5, 3, 9, 1) : (c == 3) ? pack(100, 0, 50, 25) : pack(8, 6, 4, 2);
         tick(1'b1, c == 0 || c == 3 || c == 9, d, (c == 9) ? 4'd7 : 4'd2);
         total++;
         if (got_v() !== exp_v()) begin bad++; $display("FAIL back_to_back c=%0d got=%h req=%h", c, got_v(), exp_v()); end
         if (done_s === 1'b1) dones++;
         adv();
      end
      total++;
      if (dones != 2) begin bad++; $display("FAIL back_to_back_dones got=%0d req=2", dones); end
   endtask

   task automatic test_mid_reset();
      int writes = 0;
      int dones = 0;
      for (int c = 0; c < 14; c++) begin
         tick(c != 6, c == 0, pack(5, 3, 9, 1), 4'd2);
         total++;
         if (got_v() !== exp_v()) begin bad++; $display("FAIL mid_reset c=%0d got=%h req=%h", c, got_v(), exp_v()); end
         if (en_s === 1'b1) writes++;
         if (done_s === 1'b1) dones++;
         adv();
      end
      total++;
      if (writes != 2 || dones != 0) begin
         bad++; $display("FAIL mid_reset_writes got writes=%0d dones=%0d req 2 and 0", writes, dones);
      end
   endtask

   task automatic test_dup_sorted();
      for (int c = 0; c < 20; c++) begin
         tick(1'b1, c == 0 || c == 9, (c < 9) ? pack(7, 7, 7, 7) : pack(1, 2, 3, 4), 4'd9);
         total++;
         if (got_v() !== exp_v()) begin bad++; $display("FAIL dup_sorted c=%0d got=%h req=%h", c, got_v(), exp_v()); end
         adv();
      end
   endtask

   task automatic test_random();
      logic [N*W-1:0] d;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
               0:       d[k*W +: W] = W'($urandom_range(0, 3));
               1:       d[k*W +: W] = 32'h8000_0000 + W'($urandom_range(0, 3));
               default: d[k*W +: W] = $urandom;
            endcase
         end
         tick($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, d, 4'($urandom_range(0, 15)));
         total++;
         if (got_v() !== exp_v()) begin bad++; $display("FAIL random c=%0d got=%h req=%h", c, got_v(), exp_v()); end
         adv();
      end
   endtask

   initial begin
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      t = 0;
      test_reset();
      test_basic();
      test_signedness();
      test_wrap();
      test_back_to_back();
      test_mid_reset();
      test_dup_sorted();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
